// File: rtl/fifo_rd_ctrl_pkg.sv
// Shared definitions for the asynchronous FIFO and its read-side burst controller.
package definitions;

    localparam int DATASIZE       = 8;
    localparam int ADDRSIZE       = 4;
    localparam int OBUF_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_ISSUE = 2'd1,
        RD_DRAIN = 2'd2
    } rd_state_t;

endpackage

// File: rtl/fifo_rd_ctrl_obuf.sv
// Small synchronous output FIFO sitting between the memory read port and the consumer.
// DEPTH must be a power of two so the pointers wrap naturally.
module rd_obuf #(
    parameter  int DW    = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int OW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [DW-1:0] din_i,
    input  logic          pop_i,
    output logic [OW-1:0] occ_o,
    output logic [DW-1:0] head_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [OW-1:0] occ_q;

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
        end else begin
            if (push_i) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop_i) begin
                rptr_q <= rptr_q + AW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   occ_q <= occ_q + OW'(1);
                2'b01:   occ_q <= occ_q - OW'(1);
                default: ;
            endcase
        end
    end

    assign occ_o = occ_q;
    // Gate with occupancy so the data output reads zero whenever nothing is held.
    assign head_o = (occ_q != '0) ? mem_q[rptr_q] : '0;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side burst controller: issues memory reads against the empty flag, buffers the
// returned words and hands exactly burst_len of them to a valid/ready consumer.
module fifo_rd_ctrl
    import definitions::*;
#(
    parameter int OBUF_DEPTH = OBUF_DEPTH_DEF
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic                remty,
    input  logic [DATASIZE-1:0] rdata,
    output logic                rack,
    input  logic                start,
    input  logic [ADDRSIZE:0]   burst_len,
    output logic                busy,
    output logic                done,
    output logic [ADDRSIZE:0]   rd_count,
    output logic [DATASIZE-1:0] dout,
    output logic                dvalid,
    input  logic                dready
);

    localparam int             CW      = ADDRSIZE + 1;
    localparam int             OW      = $clog2(OBUF_DEPTH) + 1;
    localparam logic [OW:0]    DEPTH_V = OBUF_DEPTH[OW:0];

    rd_state_t     state_q;
    logic [CW-1:0] len_q;
    logic [CW-1:0] issued_q;
    logic [CW-1:0] issued_d;
    logic [CW-1:0] rd_count_q;
    logic [CW-1:0] rd_count_d;
    logic          pend_q;
    logic          busy_q;
    logic          done_q;

    logic [OW-1:0] occ;
    logic [OW:0]   occ_plus_pend;
    logic          accept;
    logic          hs;
    logic          last_hs;

    rd_obuf #(
        .DW    (DATASIZE),
        .DEPTH (OBUF_DEPTH)
    ) u_obuf (
        .clk    (rclk),
        .rst_n  (rrst_n),
        .push_i (pend_q),
        .din_i  (rdata),
        .pop_i  (hs),
        .occ_o  (occ),
        .head_o (dout)
    );

    // Reserve a buffer slot for the word still in flight so backpressure never overflows.
    assign occ_plus_pend = {1'b0, occ} + {{OW{1'b0}}, pend_q};
    assign rack    = (state_q == RD_ISSUE) && (issued_q < len_q) && (occ_plus_pend < DEPTH_V);
    assign accept  = rack & ~remty;
    assign dvalid  = (occ != '0);
    assign hs      = dvalid & dready;

    assign issued_d   = issued_q + CW'(1);
    assign rd_count_d = rd_count_q + CW'(1);
    assign last_hs    = hs && (rd_count_d == len_q);

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q    <= RD_IDLE;
            len_q      <= '0;
            issued_q   <= '0;
            rd_count_q <= '0;
            pend_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            pend_q <= accept;
            if (accept) begin
                issued_q <= issued_d;
            end
            if (hs) begin
                rd_count_q <= rd_count_d;
            end
            case (state_q)
                RD_IDLE: begin
                    if (start) begin
                        rd_count_q <= '0;
                        if (burst_len != '0) begin
                            len_q    <= burst_len;
                            issued_q <= '0;
                            busy_q   <= 1'b1;
                            state_q  <= RD_ISSUE;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                RD_ISSUE: begin
                    if (last_hs) begin
                        state_q <= RD_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (accept && (issued_d == len_q)) begin
                        state_q <= RD_DRAIN;
                    end
                end
                RD_DRAIN: begin
                    if (last_hs) begin
                        state_q <= RD_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= RD_IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_count = rd_count_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: a queue-based memory model feeds the controller and every
// delivered word is compared against the order in which words were written.
module tb_fifo_rd_ctrl;
    import definitions::*;

    localparam int DEPTH   = OBUF_DEPTH_DEF;
    localparam int MEM_CAP = 1 << ADDRSIZE;
    localparam int CW      = ADDRSIZE + 1;

    logic                rclk      = 1'b0;
    logic                rrst_n    = 1'b0;
    logic                remty     = 1'b1;
    logic [DATASIZE-1:0] rdata     = '0;
    logic                start     = 1'b0;
    logic [CW-1:0]       burst_len = '0;
    logic                dready    = 1'b0;
    logic                rack;
    logic                busy;
    logic                done;
    logic [CW-1:0]       rd_count;
    logic [DATASIZE-1:0] dout;
    logic                dvalid;

    fifo_rd_ctrl #(.OBUF_DEPTH(DEPTH)) dut (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .remty     (remty),
        .rdata     (rdata),
        .rack      (rack),
        .start     (start),
        .burst_len (burst_len),
        .busy      (busy),
        .done      (done),
        .rd_count  (rd_count),
        .dout      (dout),
        .dvalid    (dvalid),
        .dready    (dready)
    );

    always #5 rclk = ~rclk;

    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc = 0, hs_cnt = 0, acc_cnt = 0, done_cnt = 0, outst = 0;
    int  first_hs_cyc = -1, last_hs_cyc = -1;
    bit  busy_seen = 1'b0, prev_done = 1'b0, rand_wr = 1'b0, rand_rdy = 1'b0;
    logic [DATASIZE-1:0] mem_q[$];
    logic [DATASIZE-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic write_word(input logic [DATASIZE-1:0] w);
        mem_q.push_back(w);
        exp_q.push_back(w);
        remty = 1'b0;
    endtask

    // One clock: observe the pre-edge handshakes, then play the memory's side of the edge.
    task automatic tick();
        bit acc;
        bit hs;
        logic [DATASIZE-1:0] w;
        if (rand_rdy) dready = ($urandom_range(0, 9) < 7);
        acc = rack && !remty;
        hs  = dvalid && dready;
        if (hs) begin
            chk("hs_avail", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                chk("dout", 32'(dout), 32'(w));
            end
            $display("hs    cyc=%0d dout=%02h rd_count=%0d", cyc, dout, rd_count);
            if (first_hs_cyc < 0) first_hs_cyc = cyc;
            last_hs_cyc = cyc;
            hs_cnt++;
            outst--;
        end
        if (done) begin
            done_cnt++;
            chk("done_busy", 32'(busy), 32'd0);
            chk("done_width", 32'(prev_done), 32'd0);
            $display("done  cyc=%0d rd_count=%0d", cyc, rd_count);
        end
        prev_done = done;
        busy_seen = busy_seen | busy;
        @(posedge rclk);
        #1;
        cyc++;
        if (acc) begin
            rdata = mem_q.pop_front();
            acc_cnt++;
            outst++;
            chk("no_overissue", 32'(outst <= DEPTH), 32'd1);
        end
        if (rand_wr && mem_q.size() < MEM_CAP && $urandom_range(0, 1) == 1)
            write_word(DATASIZE'($urandom));
        remty = (mem_q.size() == 0);
    endtask

    task automatic start_burst(input int len);
        burst_len = CW'(len);
        start = 1'b1;
        tick();
        start = 1'b0;
        $display("start cyc=%0d len=%0d", cyc, len);
    endtask

    task automatic wait_done(input int budget);
        int d0;
        d0 = done_cnt;
        for (int k = 0; k < budget && done_cnt == d0; k++) tick();
    endtask

    initial begin
        int h0, d0, a0, s_cyc, len;

        // Reset values
        repeat (3) tick();
        chk("rst_rack", 32'(rack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dvalid", 32'(dvalid), 32'd0);
        chk("rst_rd_count", 32'(rd_count), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        rrst_n = 1'b1;
        tick();

        // Basic burst of 5 with no backpressure
        for (int i = 0; i < 5; i++) write_word(DATASIZE'(8'h11 + i));
        dready = 1'b1;
        h0 = hs_cnt; d0 = done_cnt; first_hs_cyc = -1;
        start_burst(5);
        s_cyc = cyc;
        wait_done(40);
        chk("b_done", 32'(done_cnt - d0), 32'd1);
        chk("b_hs", 32'(hs_cnt - h0), 32'd5);
        chk("b_rd_count", 32'(rd_count), 32'd5);
        chk("b_latency", 32'(first_hs_cyc - s_cyc), 32'd2);
        chk("b_back_to_back", 32'(last_hs_cyc - first_hs_cyc), 32'd4);
        chk("b_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        chk("b_done_once", 32'(done_cnt - d0), 32'd1);
        chk("b_rd_count_held", 32'(rd_count), 32'd5);

        // Empty stall, then words arrive
        h0 = hs_cnt; d0 = done_cnt; a0 = acc_cnt;
        start_burst(3);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("s_dvalid", 32'(dvalid), 32'd0);
        end
        chk("s_rack_held", 32'(rack), 32'd1);
        chk("s_no_accept", 32'(acc_cnt - a0), 32'd0);
        for (int i = 0; i < 3; i++) write_word(DATASIZE'(8'h21 + i));
        wait_done(40);
        chk("s_hs", 32'(hs_cnt - h0), 32'd3);
        chk("s_done", 32'(done_cnt - d0), 32'd1);
        chk("s_rd_count", 32'(rd_count), 32'd3);

        // Backpressure on a full-length burst from a full memory
        dready = 1'b0;
        for (int i = 0; i < MEM_CAP; i++) write_word(DATASIZE'(8'h40 + i));
        h0 = hs_cnt; d0 = done_cnt; a0 = acc_cnt;
        start_burst(MEM_CAP);
        repeat (10) tick();
        chk("p_accepts", 32'(acc_cnt - a0), 32'(DEPTH));
        chk("p_rack_low", 32'(rack), 32'd0);
        chk("p_dvalid", 32'(dvalid), 32'd1);
        chk("p_no_hs", 32'(hs_cnt - h0), 32'd0);
        dready = 1'b1;
        wait_done(100);
        chk("p_hs", 32'(hs_cnt - h0), 32'(MEM_CAP));
        chk("p_rd_count", 32'(rd_count), 32'(MEM_CAP));
        chk("p_accepts_total", 32'(acc_cnt - a0), 32'(MEM_CAP));
        chk("p_done", 32'(done_cnt - d0), 32'd1);

        // Zero-length burst
        busy_seen = 1'b0; d0 = done_cnt;
        start_burst(0);
        repeat (3) tick();
        chk("z_done", 32'(done_cnt - d0), 32'd1);
        chk("z_busy", 32'(busy_seen), 32'd0);
        chk("z_rd_count", 32'(rd_count), 32'd0);

        // Start while busy is ignored
        for (int i = 0; i < 4; i++) write_word(DATASIZE'(8'h51 + i));
        h0 = hs_cnt; d0 = done_cnt; a0 = acc_cnt;
        start_burst(4);
        burst_len = CW'(2);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(40);
        chk("i_hs", 32'(hs_cnt - h0), 32'd4);
        chk("i_rd_count", 32'(rd_count), 32'd4);
        repeat (4) tick();
        chk("i_done", 32'(done_cnt - d0), 32'd1);
        chk("i_idle", 32'(busy), 32'd0);
        chk("i_accepts", 32'(acc_cnt - a0), 32'd4);

        // Reset after two of eight words
        for (int i = 0; i < 8; i++) write_word(DATASIZE'(8'h61 + i));
        h0 = hs_cnt;
        start_burst(8);
        for (int k = 0; k < 20 && (hs_cnt - h0) < 2; k++) tick();
        rrst_n = 1'b0;
        #1;
        chk("r_rack", 32'(rack), 32'd0);
        chk("r_busy", 32'(busy), 32'd0);
        chk("r_done", 32'(done), 32'd0);
        chk("r_dvalid", 32'(dvalid), 32'd0);
        chk("r_dout", 32'(dout), 32'd0);
        chk("r_rd_count", 32'(rd_count), 32'd0);
        exp_q = mem_q;
        outst = 0;
        prev_done = 1'b0;
        tick();
        rrst_n = 1'b1;
        tick();
        h0 = hs_cnt; d0 = done_cnt;
        start_burst(2);
        wait_done(40);
        chk("r2_hs", 32'(hs_cnt - h0), 32'd2);
        chk("r2_done", 32'(done_cnt - d0), 32'd1);
        chk("r2_rd_count", 32'(rd_count), 32'd2);

        // Randomized bursts with random writes and random consumer readiness
        rand_wr = 1'b1;
        rand_rdy = 1'b1;
        for (int b = 0; b < 12; b++) begin
            len = $urandom_range(1, MEM_CAP);
            h0 = hs_cnt; d0 = done_cnt; a0 = acc_cnt;
            start_burst(len);
            wait_done(600);
            chk("rnd_hs", 32'(hs_cnt - h0), 32'(len));
            chk("rnd_rd_count", 32'(rd_count), 32'(len));
            chk("rnd_done", 32'(done_cnt - d0), 32'd1);
            chk("rnd_accepts", 32'(acc_cnt - a0), 32'(len));
            $display("burst %0d len=%0d complete cyc=%0d", b, len, cyc);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
